// File: rtl/uart_pkg.sv
// ---------------------------------------------------------------------------
// uart_pkg: receiver state encoding and the ASCII constants the parser uses.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_t;

  localparam logic [7:0] ASCII_ZERO  = 8'h30;
  localparam logic [7:0] ASCII_NINE  = 8'h39;
  localparam logic [7:0] ASCII_SPACE = 8'h20;
  localparam logic [7:0] ASCII_CR    = 8'h0D;
  localparam logic [7:0] ASCII_LF    = 8'h0A;

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  function automatic logic is_digit(input logic [7:0] ch);
    return (ch >= ASCII_ZERO) && (ch <= ASCII_NINE);
  endfunction

  function automatic logic is_separator(input logic [7:0] ch);
    return (ch == ASCII_SPACE) || (ch == ASCII_CR) || (ch == ASCII_LF);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ---------------------------------------------------------------------------
// uart_baud_tick: free-running divider producing one oversample tick per DIV clocks.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_baud_tick #(
  parameter int DIV = 54
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear || (cnt == LAST)) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

  assign tick = (cnt == LAST) && !clear;

endmodule

`default_nettype wire

// File: rtl/uart_rx_deframer.sv
// ---------------------------------------------------------------------------
// uart_rx_deframer: oversampling UART receiver with 2-of-3 mid-bit voting,
// false-start rejection, framing-error/break handling. Optional: PARITY_EN (even parity).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module uart_rx_deframer #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int BAUD_RATE   = 115200,
  parameter int OVERSAMPLE  = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_done,
  output logic       frame_error,
  output logic       parity_error,
  output logic       rx_busy
);

  import uart_pkg::*;

  localparam int DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
  localparam int TW  = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] T_S0   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] T_S1   = TW'(OVERSAMPLE / 2);
  localparam logic [TW-1:0] T_DEC  = TW'(OVERSAMPLE / 2 + 1);
  localparam logic [TW-1:0] T_LAST = TW'(OVERSAMPLE - 1);

  logic          rx_meta;
  logic          rxs;
  uart_state_t   state;
  logic [TW-1:0] tick_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          s0;
  logic          s1;
  logic          tick;
  logic          baud_clear;
  logic          at_dec;
  logic          vote;
`ifdef PARITY_EN
  logic          parity_bad;
`endif

  // Flops preset to idle-high so reset release never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta <= 1'b1;
      rxs     <= 1'b1;
    end else begin
      rx_meta <= rx;
      rxs     <= rx_meta;
    end
  end

  assign baud_clear = (state == IDLE) && !rxs;
  assign at_dec     = tick && (tick_cnt == T_DEC);
  assign vote       = majority3(s0, s1, rxs);

  uart_baud_tick #(
    .DIV (DIV)
  ) u_baud_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (baud_clear),
    .tick  (tick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      tick_cnt    <= '0;
      bit_cnt     <= '0;
      shreg       <= '0;
      s0          <= 1'b1;
      s1          <= 1'b1;
      rx_data     <= '0;
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
      rx_busy     <= 1'b0;
`ifdef PARITY_EN
      parity_bad   <= 1'b0;
      parity_error <= 1'b0;
`endif
    end else begin
      rx_done     <= 1'b0;
      frame_error <= 1'b0;
`ifdef PARITY_EN
      parity_error <= 1'b0;
`endif
      if (tick && (state != IDLE) && (state != BREAK)) begin
        tick_cnt <= (tick_cnt == T_LAST) ? '0 : tick_cnt + TW'(1);
        if (tick_cnt == T_S0) s0 <= rxs;
        if (tick_cnt == T_S1) s1 <= rxs;
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            rx_busy  <= 1'b1;
            tick_cnt <= '0;
            bit_cnt  <= '0;
          end
        end
        START: begin
          if (at_dec) begin
            if (vote) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (at_dec) begin
            shreg   <= {vote, shreg[7:1]};
            bit_cnt <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd7) begin
`ifdef PARITY_EN
              state <= PARITY;
`else
              state <= STOP;
`endif
            end
          end
        end
`ifdef PARITY_EN
        PARITY: begin
          if (at_dec) begin
            parity_bad <= vote ^ (^shreg);
            state      <= STOP;
          end
        end
`endif
        STOP: begin
          // Leave at mid stop bit so a start edge in its second half is caught.
          if (at_dec) begin
            if (!vote) begin
              frame_error <= 1'b1;
              state       <= BREAK;
              tick_cnt    <= '0;
            end else begin
`ifdef PARITY_EN
              if (parity_bad) begin
                parity_error <= 1'b1;
              end else begin
                rx_data <= shreg;
                rx_done <= 1'b1;
              end
`else
              rx_data <= shreg;
              rx_done <= 1'b1;
`endif
              state   <= IDLE;
              rx_busy <= 1'b0;
            end
          end
        end
        BREAK: begin
          // Need one uninterrupted bit time of idle-high before re-arming.
          if (!rxs) begin
            tick_cnt <= '0;
          end else if (tick) begin
            if (tick_cnt == T_LAST) begin
              state   <= IDLE;
              rx_busy <= 1'b0;
            end else begin
              tick_cnt <= tick_cnt + TW'(1);
            end
          end
        end
        default: begin
          state   <= IDLE;
          rx_busy <= 1'b0;
        end
      endcase
    end
  end

`ifndef PARITY_EN
  assign parity_error = 1'b0;
`endif

endmodule

`default_nettype wire
